// File: rtl/bpu_pkg.sv
// Shared types and counter helpers for the branch prediction unit.
// Counter helpers work on an 8-bit container; callers cast to their own width.
package bpu_pkg;

  localparam int CTR_W_MAX = 8;

  typedef enum logic [1:0] {
    REDIR_SEQ   = 2'd0,
    REDIR_PRED  = 2'd1,
    REDIR_FLUSH = 2'd2
  } redirect_e;

  function automatic logic [CTR_W_MAX-1:0] ctr_all_ones(input int n);
    logic [CTR_W_MAX:0] t;
    t = ({{CTR_W_MAX{1'b0}}, 1'b1} << n) - 1'b1;
    return t[CTR_W_MAX-1:0];
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_weak_taken(input int n);
    return {{(CTR_W_MAX-1){1'b0}}, 1'b1} << (n - 1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_weak_not_taken(input int n);
    return ctr_weak_taken(n) - 1'b1;
  endfunction

  function automatic logic [CTR_W_MAX-1:0] sat_inc(input logic [CTR_W_MAX-1:0] ctr, input int n);
    return (ctr == ctr_all_ones(n)) ? ctr : ctr + 1'b1;
  endfunction

  function automatic logic [CTR_W_MAX-1:0] sat_dec(input logic [CTR_W_MAX-1:0] ctr, input int n);
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/btb_ctr_next.sv
// Next direction-counter value for one resolved branch.
// A miss that is taken allocates at weakly-taken; a not-taken miss leaves the counter alone.
module btb_ctr_next
  import bpu_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] i_ctr,
  input  logic                i_hit,
  input  logic                i_taken,
  output logic [CTR_BITS-1:0] o_ctr
);
  logic [CTR_W_MAX-1:0] w_ctr_ext;

  assign w_ctr_ext = CTR_W_MAX'(i_ctr);

  always_comb begin
    o_ctr = i_ctr;
    if (i_hit && i_taken)
      o_ctr = CTR_BITS'(sat_inc(w_ctr_ext, CTR_BITS));
    else if (i_hit)
      o_ctr = CTR_BITS'(sat_dec(w_ctr_ext, CTR_BITS));
    else if (i_taken)
      o_ctr = CTR_BITS'(ctr_weak_taken(CTR_BITS));
  end
endmodule

// File: rtl/mux_2.sv
// Two-input mux: o_y = i_sel ? i_b : i_a.
module mux_2 #(
  parameter int WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/pc_inc.sv
// Sequential next-PC adder; wraps modulo 2^WIDTH.
module pc_inc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_pc,
  output logic [WIDTH-1:0] o_pc
);
  assign o_pc = i_pc + WIDTH'(4);
endmodule

// File: rtl/btb_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB with per-entry saturating counters,
// trained by execute-stage resolutions and overridden by execute flushes.
module btb_predictor
  import bpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_fetch,
  input  logic [WIDTH-1:0] pc_circuit,
  input  logic             flush,
  input  logic             upd_en,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_taken,
  input  logic             upd_is_jump,
  output logic [WIDTH-1:0] pc_next,
  output logic             branch_predicted,
  output logic             btb_hit
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = WIDTH - 2 - IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag     [ENTRIES];
  logic [WIDTH-1:0]    r_target  [ENTRIES];
  logic [ENTRIES-1:0]  r_is_jump;
  logic [CTR_BITS-1:0] r_ctr     [ENTRIES];

  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_BITS-1:0] w_f_tag;
  logic [CTR_BITS-1:0] w_f_ctr;
  logic                w_f_hit;
  logic                w_taken_p;
  logic [WIDTH-1:0]    w_pc_seq;
  logic [WIDTH-1:0]    w_pc_pred;
  redirect_e           w_redirect;

  logic [IDX_BITS-1:0] w_u_idx;
  logic [TAG_BITS-1:0] w_u_tag;
  logic                w_u_hit;
  logic [CTR_BITS-1:0] w_ctr_nxt;
  logic                w_unused_upd_lsb;

  // Lookup: purely combinational, always sees the registered (pre-update) contents.
  assign w_f_idx   = pc_fetch[IDX_BITS+1:2];
  assign w_f_tag   = pc_fetch[WIDTH-1:IDX_BITS+2];
  assign w_f_ctr   = r_ctr[w_f_idx];
  assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_taken_p = w_f_hit && (r_is_jump[w_f_idx] || w_f_ctr[CTR_BITS-1]);

  assign w_redirect = flush     ? REDIR_FLUSH :
                      w_taken_p ? REDIR_PRED  : REDIR_SEQ;

  pc_inc #(.WIDTH(WIDTH)) u_pc_inc (
    .i_pc (pc_fetch),
    .o_pc (w_pc_seq)
  );

  mux_2 #(.WIDTH(WIDTH)) u_mux_pred (
    .i_sel (w_taken_p),
    .i_a   (w_pc_seq),
    .i_b   (r_target[w_f_idx]),
    .o_y   (w_pc_pred)
  );

  mux_2 #(.WIDTH(WIDTH)) u_mux_flush (
    .i_sel (flush),
    .i_a   (w_pc_pred),
    .i_b   (pc_circuit),
    .o_y   (pc_next)
  );

  assign btb_hit          = w_f_hit;
  assign branch_predicted = (w_redirect == REDIR_PRED);

  assign w_u_idx          = upd_pc[IDX_BITS+1:2];
  assign w_u_tag          = upd_pc[WIDTH-1:IDX_BITS+2];
  assign w_u_hit          = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_unused_upd_lsb = ^upd_pc[1:0];

  btb_ctr_next #(.CTR_BITS(CTR_BITS)) u_ctr_next (
    .i_ctr   (r_ctr[w_u_idx]),
    .i_hit   (w_u_hit),
    .i_taken (upd_taken),
    .o_ctr   (w_ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RST;
    end else if (upd_en && (w_u_hit || upd_taken)) begin
      r_ctr[w_u_idx] <= w_ctr_nxt;
      if (upd_taken) r_valid[w_u_idx] <= 1'b1;
    end
  end

  // Payload fields are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      r_tag[w_u_idx]     <= w_u_tag;
      r_target[w_u_idx]  <= upd_target;
      r_is_jump[w_u_idx] <= upd_is_jump;
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed scenarios plus random traffic against a table model.
module tb_btb_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_fetch, pc_circuit, upd_pc, upd_target, pc_next;
  logic        flush, upd_en, upd_taken, upd_is_jump;
  logic        branch_predicted, btb_hit;

  int n_cmp = 0;
  int n_mis = 0;

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_target[16];
  bit          m_jump  [16];
  int          m_ctr   [16];

  logic        e_hit, e_pred;
  logic [31:0] e_next;

  btb_predictor #(.WIDTH(32), .ENTRIES(16), .CTR_BITS(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_fetch         (pc_fetch),
    .pc_circuit       (pc_circuit),
    .flush            (flush),
    .upd_en           (upd_en),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_taken        (upd_taken),
    .upd_is_jump      (upd_is_jump),
    .pc_next          (pc_next),
    .branch_predicted (branch_predicted),
    .btb_hit          (btb_hit)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_lookup();
    int          idx;
    logic [25:0] tag;
    idx    = int'((pc_fetch >> 2) % 16);
    tag    = 26'(pc_fetch >> 6);
    e_hit  = m_valid[idx] && (m_tag[idx] == tag);
    e_pred = e_hit && (m_jump[idx] || m_ctr[idx] >= 2) && !flush;
    if (flush)
      e_next = pc_circuit;
    else if (e_hit && (m_jump[idx] || m_ctr[idx] >= 2))
      e_next = m_target[idx];
    else
      e_next = pc_fetch + 32'd4;
  endfunction

  function automatic void model_update();
    int          idx;
    logic [25:0] tag;
    idx = int'((upd_pc >> 2) % 16);
    tag = 26'(upd_pc >> 6);
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (upd_taken) begin
        m_ctr[idx]    = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
        m_target[idx] = upd_target;
        m_jump[idx]   = upd_is_jump;
      end else begin
        m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (upd_taken) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = tag;
      m_target[idx] = upd_target;
      m_jump[idx]   = upd_is_jump;
      m_ctr[idx]    = 2;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst && upd_en) model_update();
    #1;
  endtask

  task automatic set_upd(input logic en, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic jp);
    upd_en = en; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_is_jump = jp;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; pc_circuit = 32'h0; pc_fetch = 32'h100;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (btb_hit !== 1'b0) begin n_mis++; $display("FAIL rst_hit: got %b want 0", btb_hit); end
    n_cmp++; if (branch_predicted !== 1'b0) begin n_mis++; $display("FAIL rst_pred: got %b want 0", branch_predicted); end
    n_cmp++; if (pc_next !== 32'h104) begin n_mis++; $display("FAIL rst_next: got %h want 00000104", pc_next); end
    flush = 1'b1; pc_circuit = 32'h3000; #1;
    n_cmp++; if (pc_next !== 32'h3000) begin n_mis++; $display("FAIL rst_flush_next: got %h want 00003000", pc_next); end
    flush = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick();
    n_cmp++; if (pc_next !== 32'h104 || btb_hit !== 1'b0) begin
      n_mis++; $display("FAIL post_rst: got next=%h hit=%b want 00000104/0", pc_next, btb_hit);
    end
  endtask

  task automatic test_train();
    pc_fetch = 32'h100;
    set_upd(1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (btb_hit !== 1'b1) begin n_mis++; $display("FAIL train_hit: got %b want 1", btb_hit); end
    n_cmp++; if (branch_predicted !== 1'b1) begin n_mis++; $display("FAIL train_pred: got %b want 1", branch_predicted); end
    n_cmp++; if (pc_next !== 32'h200) begin n_mis++; $display("FAIL train_next: got %h want 00000200", pc_next); end
  endtask

  task automatic test_saturate();
    bit outc [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    bit expp [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    pc_fetch = 32'h100;
    for (int i = 0; i < 8; i++) begin
      set_upd(1'b1, 32'h100, 32'h200, outc[i], 1'b0);
      tick();
      set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      model_lookup();
      n_cmp++; if (branch_predicted !== expp[i]) begin
        n_mis++; $display("FAIL sat_pred[%0d]: got %b want %b", i, branch_predicted, expp[i]);
      end
      n_cmp++; if (btb_hit !== 1'b1 || pc_next !== e_next) begin
        n_mis++; $display("FAIL sat_next[%0d]: got hit=%b next=%h want 1/%h", i, btb_hit, pc_next, e_next);
      end
    end
  endtask

  task automatic test_alias();
    set_upd(1'b1, 32'h140, 32'h5550, 1'b1, 1'b0);
    pc_fetch = 32'h100;
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (btb_hit !== 1'b0 || pc_next !== 32'h104) begin
      n_mis++; $display("FAIL alias_evict: got hit=%b next=%h want 0/00000104", btb_hit, pc_next);
    end
    pc_fetch = 32'h140; #1;
    n_cmp++; if (btb_hit !== 1'b1 || pc_next !== 32'h5550) begin
      n_mis++; $display("FAIL alias_new: got hit=%b next=%h want 1/00005550", btb_hit, pc_next);
    end
    tick();
  endtask

  task automatic test_jump_flush();
    set_upd(1'b1, 32'h80, 32'h1234, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_upd(1'b1, 32'h80, 32'h0, 1'b0, 1'b0);
      tick();
    end
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pc_fetch = 32'h80; #1;
    n_cmp++; if (branch_predicted !== 1'b1 || pc_next !== 32'h1234) begin
      n_mis++; $display("FAIL jump_pred: got pred=%b next=%h want 1/00001234", branch_predicted, pc_next);
    end
    flush = 1'b1; pc_circuit = 32'h3000; #1;
    n_cmp++; if (branch_predicted !== 1'b0 || pc_next !== 32'h3000 || btb_hit !== 1'b1) begin
      n_mis++; $display("FAIL jump_flush: got pred=%b next=%h hit=%b want 0/00003000/1",
                        branch_predicted, pc_next, btb_hit);
    end
    // Flush alongside an update: the update still lands.
    set_upd(1'b1, 32'h84, 32'h4440, 1'b1, 1'b0);
    tick();
    flush = 1'b0; set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pc_fetch = 32'h84; #1;
    n_cmp++; if (pc_next !== 32'h4440) begin n_mis++; $display("FAIL flush_upd: got %h want 00004440", pc_next); end
    tick();
  endtask

  task automatic test_same_cycle();
    pc_fetch = 32'h100;
    set_upd(1'b1, 32'h100, 32'h700, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (btb_hit !== 1'b0 || pc_next !== 32'h104) begin
      n_mis++; $display("FAIL same_cycle_miss: got hit=%b next=%h want 0/00000104", btb_hit, pc_next);
    end
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (btb_hit !== 1'b1 || pc_next !== 32'h700) begin
      n_mis++; $display("FAIL same_cycle_hit: got hit=%b next=%h want 1/00000700", btb_hit, pc_next);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (btb_hit !== 1'b0 || branch_predicted !== 1'b0 || pc_next !== 32'h104) begin
      n_mis++; $display("FAIL async_rst: got hit=%b pred=%b next=%h want 0/0/00000104",
                        btb_hit, branch_predicted, pc_next);
    end
    pc_fetch = 32'hFFFF_FFFC; #1;
    n_cmp++; if (pc_next !== 32'h0) begin n_mis++; $display("FAIL wrap: got %h want 00000000", pc_next); end
    rst = 1'b0;
    model_reset();
    pc_fetch = 32'h100; #1;
    n_cmp++; if (btb_hit !== 1'b0) begin n_mis++; $display("FAIL post_async_hit: got %b want 0", btb_hit); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      pc_fetch   = {24'(($urandom_range(0, 2)) << 2), 4'($urandom_range(0, 3)), 2'b00, 2'($urandom)};
      pc_fetch   = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 7) == 0);
      pc_circuit = $urandom;
      set_upd($urandom_range(0, 1) == 1,
              (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2),
              $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
      @(negedge clk);
      model_lookup();
      n_cmp++; if (btb_hit !== e_hit || branch_predicted !== e_pred || pc_next !== e_next) begin
        n_mis++; $display("FAIL rand[%0d] pc=%h: got hit=%b pred=%b next=%h want %b/%b/%h",
                          i, pc_fetch, btb_hit, branch_predicted, pc_next, e_hit, e_pred, e_next);
      end
      tick();
    end
    flush = 1'b0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturate();
    test_alias();
    test_jump_flush();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
